// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32 sequencer: states, opcodes, mux selects, fault codes.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_FAULT  = 3'd6
    } state_e;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] ALU_SRC_A_PC    = 2'b00;
    localparam logic [1:0] ALU_SRC_A_RS1   = 2'b01;
    localparam logic [1:0] ALU_SRC_A_OLDPC = 2'b10;

    localparam logic [1:0] ALU_SRC_B_RS2  = 2'b00;
    localparam logic [1:0] ALU_SRC_B_FOUR = 2'b01;
    localparam logic [1:0] ALU_SRC_B_IMM  = 2'b10;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    function automatic logic is_legal(input logic [6:0] op);
        return (op == OP_RTYPE) || (op == OP_LOAD) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_watchdog.sv
// Counts unacknowledged request cycles; flags expiry on the last allowed cycle without ack.
module mem_watchdog #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic active,
    input  logic ack,
    output logic expired
);
    localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (active && !ack) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // An ack on the final cycle wins over expiry; MEM_TIMEOUT of zero disables the check.
    assign expired = (MEM_TIMEOUT != 0) && active && !ack && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with shared memory port, watchdog and retire counter.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic             alu_zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [2:0]       state_o
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fault_q, fault_d;
    logic [1:0]       fault_code_q, fault_code_d;
    logic             wd_expired;

    mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_d != state_q),
        .active  (mem_req),
        .ack     (mem_ack),
        .expired (wd_expired)
    );

    // Next-state and control decode; outputs are combinational in state plus ack/zero.
    always_comb begin
        state_d      = state_q;
        fault_code_d = fault_code_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        iord         = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        alu_src_a    = ALU_SRC_A_PC;
        alu_src_b    = ALU_SRC_B_RS2;
        alu_op       = ALU_OP_ADD;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        instr_done   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = ALU_SRC_B_FOUR;
                if (mem_ack) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (wd_expired) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FAULT_TIMEOUT;
                end
            end
            ST_DECODE: begin
                alu_src_a = ALU_SRC_A_OLDPC;
                alu_src_b = ALU_SRC_B_IMM;
                if (is_legal(opcode)) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d      = ST_FAULT;
                    fault_code_d = FAULT_ILLEGAL;
                end
            end
            ST_EXEC: begin
                alu_src_a = ALU_SRC_A_RS1;
                case (opcode)
                    OP_RTYPE: begin
                        alu_op  = ALU_OP_FUNCT;
                        state_d = ST_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_b = ALU_SRC_B_IMM;
                        state_d   = ST_MEM;
                    end
                    OP_BRANCH: begin
                        alu_op     = ALU_OP_SUB;
                        pc_write   = alu_zero;
                        pc_src     = 1'b1;
                        instr_done = 1'b1;
                        state_d    = ST_FETCH;
                    end
                    default: begin
                        state_d      = ST_FAULT;
                        fault_code_d = FAULT_ILLEGAL;
                    end
                endcase
            end
            ST_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (opcode == OP_STORE);
                if (mem_ack) begin
                    if (opcode == OP_STORE) begin
                        instr_done = 1'b1;
                        state_d    = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (wd_expired) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FAULT_TIMEOUT;
                end
            end
            ST_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (opcode == OP_LOAD);
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign fault_d = fault_q | (state_d == ST_FAULT);
    assign count_d = count_q + CNT_W'(instr_done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= FAULT_NONE;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
        end
    end

    assign instr_count = count_q;
    assign fault       = fault_q;
    assign fault_code  = fault_code_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction cycle schedules built from the state table, checked every cycle.
module tb_multicycle_ctrl;
    localparam int unsigned TMO = 16;
    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                           S_MEM = 3'd4, S_WB = 3'd5, S_FAULT = 3'd6;
    localparam logic [6:0] OPR = 7'b0110011, OPLD = 7'b0000011, OPSD = 7'b0100011,
                           OPBR = 7'b1100011, OPBAD = 7'b1111111;

    logic        clk, rst_n, run, alu_zero, mem_ack;
    logic [6:0]  opcode;
    logic        mem_req, mem_we, iord, ir_write, pc_write, pc_src;
    logic [1:0]  alu_src_a, alu_src_b, alu_op;
    logic        reg_write, mem_to_reg, instr_done, fault;
    logic [31:0] instr_count;
    logic [1:0]  fault_code;
    logic [2:0]  state_o;
    logic [14:0] ctl_dut;

    multicycle_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .alu_zero(alu_zero),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .instr_done(instr_done),
        .instr_count(instr_count), .fault(fault), .fault_code(fault_code), .state_o(state_o)
    );

    assign ctl_dut = {mem_req, mem_we, iord, ir_write, pc_write, pc_src,
                      alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, instr_done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        run, ack, z;
        logic [6:0]  op;
        logic [2:0]  st;
        logic [14:0] ctl;
        logic        flt;
        logic [1:0]  fc;
        logic [31:0] cnt;
    } cyc_t;

    cyc_t        plan[$];
    logic [31:0] m_cnt;
    logic        m_flt;
    logic [1:0]  m_fc;
    int          n_pass, n_total;

    function automatic logic [14:0] mk(input logic req, we, io, irw, pcw, pcs,
                                       input logic [1:0] a, b, aop,
                                       input logic rw, m2r, done);
        return {req, we, io, irw, pcw, pcs, a, b, aop, rw, m2r, done};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic push(input logic [2:0] st, input logic rn, ak, z,
                        input logic [6:0] op, input logic [14:0] c);
        cyc_t e;
        e.run = rn; e.ack = ak; e.z = z; e.op = op; e.st = st; e.ctl = c;
        e.flt = m_flt; e.fc = m_fc; e.cnt = m_cnt;
        plan.push_back(e);
        if (c[0]) m_cnt = m_cnt + 32'd1;
    endtask

    // A memory phase: 'waits' cycles without ack (faulting on the TMO-th), then an ack cycle.
    task automatic plan_mem(input bit is_fetch, input int waits, input logic [6:0] op,
                            input logic z, output bit faulted);
        logic [14:0] wc;
        logic [2:0]  st;
        faulted = 1'b0;
        st = is_fetch ? S_FETCH : S_MEM;
        wc = is_fetch ? mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 0, 0, 0)
                      : mk(1, op == OPSD, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        for (int k = 1; k <= waits; k++) begin
            push(st, 0, 0, z, op, wc);
            if (k == int'(TMO)) begin
                m_flt = 1'b1; m_fc = 2'b10; faulted = 1'b1;
                return;
            end
        end
        if (is_fetch) push(st, 0, 1, z, op, wc | mk(0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0));
        else          push(st, 0, 1, z, op, wc | 15'(op == OPSD));
    endtask

    task automatic plan_instr(input logic [6:0] op, input int fw, input int mw, input logic z);
        bit f;
        plan_mem(1, fw, op, z, f);
        if (f) return;
        push(S_DECODE, 0, 0, z, op, mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 2'b00, 0, 0, 0));
        if (!(op == OPR || op == OPLD || op == OPSD || op == OPBR)) begin
            m_flt = 1'b1; m_fc = 2'b01;
            return;
        end
        if (op == OPBR) begin
            push(S_EXEC, 0, 0, z, op, mk(0, 0, 0, 0, z, 1, 2'b01, 2'b00, 2'b01, 0, 0, 1));
            return;
        end
        if (op == OPR) begin
            push(S_EXEC, 0, 0, z, op, mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b10, 0, 0, 0));
        end else begin
            push(S_EXEC, 0, 0, z, op, mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, 0, 0, 0));
            plan_mem(0, mw, op, z, f);
            if (f || op == OPSD) return;
        end
        push(S_WB, 0, 0, z, op, mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, op == OPLD, 1));
    endtask

    task automatic plan_idle(input logic rn);
        push(S_IDLE, rn, 0, 0, OPR, 15'd0);
    endtask

    task automatic plan_fault(input int n);
        for (int i = 0; i < n; i++) push(S_FAULT, 1, (i % 2) == 1, 1, OPBAD, 15'd0);
    endtask

    // Plays the planned cycles and compares every output mid-cycle.
    task automatic run_plan(output int done_at, output int n_req, output int n_iord);
        cyc_t e;
        int idx;
        idx = 0; done_at = 0; n_req = 0; n_iord = 0;
        while (plan.size() > 0) begin
            e = plan.pop_front();
            idx++;
            run = e.run; mem_ack = e.ack; alu_zero = e.z; opcode = e.op;
            @(negedge clk);
            chk("state", 32'(state_o), 32'(e.st));
            chk("ctl", 32'(ctl_dut), 32'(e.ctl));
            chk("fault", 32'(fault), 32'(e.flt));
            chk("fault_code", 32'(fault_code), 32'(e.fc));
            chk("instr_count", instr_count, e.cnt);
            if (instr_done && done_at == 0) done_at = idx;
            if (mem_req) n_req++;
            if (mem_req && iord) n_iord++;
            @(posedge clk);
            #1;
        end
        run = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        run = 1'b0; mem_ack = 1'b0; rst_n = 1'b0;
        m_cnt = 32'd0; m_flt = 1'b0; m_fc = 2'b00;
        #1;
        chk("rst_state", 32'(state_o), 32'(S_IDLE));
        chk("rst_ctl", 32'(ctl_dut), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_fault_code", 32'(fault_code), 32'd0);
        chk("rst_count", instr_count, m_cnt);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int d, nr, ni;
        rst_n = 1'b0; run = 1'b0; mem_ack = 1'b0; alu_zero = 1'b0; opcode = OPR;
        n_pass = 0; n_total = 0; m_cnt = 32'd0; m_flt = 1'b0; m_fc = 2'b00;
        do_reset();

        plan_idle(1); run_plan(d, nr, ni);
        plan_instr(OPR, 0, 0, 0); run_plan(d, nr, ni);
        chk("rtype_latency", 32'(d), 32'd4);
        chk("rtype_count", instr_count, 32'd1);

        plan_instr(OPLD, 0, 3, 0); run_plan(d, nr, ni);
        chk("load_latency", 32'(d), 32'd8);
        chk("load_req_cycles", 32'(nr), 32'd5);
        chk("load_iord_cycles", 32'(ni), 32'd4);

        plan_instr(OPSD, 1, 0, 0); run_plan(d, nr, ni);
        chk("store_latency", 32'(d), 32'd5);

        plan_instr(OPBR, 0, 0, 1); run_plan(d, nr, ni);
        chk("branch_taken_latency", 32'(d), 32'd3);
        plan_instr(OPBR, 0, 0, 0); run_plan(d, nr, ni);
        chk("branch_nt_latency", 32'(d), 32'd3);
        chk("branch_count", instr_count, 32'd5);

        plan_instr(OPR, 15, 0, 0); run_plan(d, nr, ni);
        chk("ack_at_limit_latency", 32'(d), 32'd19);
        chk("ack_at_limit_nofault", 32'(fault), 32'd0);

        plan_instr(OPBAD, 0, 0, 0); plan_fault(20); run_plan(d, nr, ni);
        chk("illegal_code", 32'(fault_code), 32'd1);
        chk("illegal_state", 32'(state_o), 32'd6);
        chk("illegal_count", instr_count, 32'd6);
        do_reset();

        plan_idle(1); plan_instr(OPR, 20, 0, 0); plan_fault(3); run_plan(d, nr, ni);
        chk("timeout_req_cycles", 32'(nr), 32'd16);
        chk("timeout_code", 32'(fault_code), 32'd2);
        do_reset();

        plan_idle(1);
        for (int i = 0; i < 3; i++)
            push(S_FETCH, 0, 0, 0, OPR, mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 0, 0, 0));
        run_plan(d, nr, ni);
        chk("pre_reset_req", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_drops_req", 32'(mem_req), 32'd0);
        chk("reset_mid_state", 32'(state_o), 32'd0);
        chk("reset_mid_count", instr_count, 32'd0);
        m_cnt = 32'd0; m_flt = 1'b0; m_fc = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        plan_idle(1); run_plan(d, nr, ni);
        plan_instr(OPR, 0, 0, 0); run_plan(d, nr, ni);
        chk("recover_latency", 32'(d), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
